// File: rtl/ising_array_model_param.sv
// Clocked behavioural stand-in for the N x N Ising array macro: weight memory with
// H/V readback, bitline precharge, divided oscillator output and LFSR-driven spin sampling.
module ising_array_model_param #(
    parameter int                  N            = 50,
    parameter int                  WEIGHT_W     = 4,
    parameter int                  SPIN_W       = 7,
    parameter int                  ANNEAL_CYC   = 16,
    parameter int                  FREQ_DIV     = 4,
    parameter logic [N*SPIN_W-1:0] SEED_PATTERN = '0,
    parameter logic [31:0]         LFSR_SEED    = 32'h1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     PRE_CHARGE_ENB,
    input  logic                     ROSC_GLOBAL_EN,
    input  logic                     SAMPLE,
    input  logic                     WEIGHT_ENB,
    input  logic                     SHIL_WEIGHT_ENB,
    input  logic [N-1:0]             WWL,
    input  logic [N*WEIGHT_W-1:0]    WBL,
    input  logic [N-1:0]             RWLH,
    input  logic [N-1:0]             RWLV,
    output logic [N*WEIGHT_W-1:0]    RBLH,
    output logic [N*WEIGHT_W-1:0]    RBLV,
    output logic                     FREQ_OUT,
    output logic [N*SPIN_W-1:0]      SPIN_OUT,
    output logic                     SPIN_VALID,
    output logic                     SAMPLE_BUSY,
    output logic [15:0]              SAMPLE_CNT
);

    localparam int RW = N * WEIGHT_W;
    localparam int ST = N * SPIN_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (FREQ_DIV > 1) ? $clog2(FREQ_DIV) : 1;
    localparam int AW = (ANNEAL_CYC > 1) ? $clog2(ANNEAL_CYC) : 1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ANNEAL = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Highest set wordline wins; caller qualifies with |wl for the "no row" case.
    function automatic logic [IW-1:0] dec_hi(input logic [N-1:0] wl);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (wl[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    logic [RW-1:0]  mem_h_q [N];
    logic [RW-1:0]  mem_h_d [N];
    logic [RW-1:0]  mem_v_q [N];
    logic [RW-1:0]  mem_v_d [N];
    logic [RW-1:0]  rblh_q, rblh_d;
    logic [RW-1:0]  rblv_q, rblv_d;
    logic [FW-1:0]  fcnt_q, fcnt_d;
    logic           freq_q, freq_d;
    logic [31:0]    lfsr_q, lfsr_d;
    state_t         state_q, state_d;
    logic [AW-1:0]  acnt_q, acnt_d;
    logic           busy_q, busy_d;
    logic           valid_q, valid_d;
    logic [ST-1:0]  spin_q, spin_d;
    logic [ST-1:0]  shadow_q, shadow_d;
    logic [15:0]    scnt_q, scnt_d;
    logic           first_q, first_d;
    logic           samp_q, samp_d;

    logic [IW-1:0]  wr_row, rh_row, rv_row;
    logic           sample_rise;

    assign wr_row      = dec_hi(WWL);
    assign rh_row      = dec_hi(RWLH);
    assign rv_row      = dec_hi(RWLV);
    assign sample_rise = SAMPLE & ~samp_q;

    // memV holds the transpose of memH, so every write lands in both.
    always_comb begin
        mem_h_d = mem_h_q;
        mem_v_d = mem_v_q;
        if (|WWL) begin
            if (!WEIGHT_ENB) begin
                mem_h_d[wr_row] = WBL;
                for (int c = 0; c < N; c++) begin
                    mem_v_d[c][wr_row*WEIGHT_W +: WEIGHT_W] = WBL[c*WEIGHT_W +: WEIGHT_W];
                end
            end else if (!SHIL_WEIGHT_ENB) begin
                mem_h_d[wr_row][wr_row*WEIGHT_W +: WEIGHT_W] = WBL[wr_row*WEIGHT_W +: WEIGHT_W];
                mem_v_d[wr_row][wr_row*WEIGHT_W +: WEIGHT_W] = WBL[wr_row*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    // Reads sample the registered memory, so a same-cycle write is not visible yet.
    always_comb begin
        rblh_d = rblh_q;
        rblv_d = rblv_q;
        if (!PRE_CHARGE_ENB) begin
            rblh_d = '1;
            rblv_d = '1;
        end else begin
            if (|RWLH) begin
                rblh_d = mem_h_q[rh_row];
            end
            if (|RWLV) begin
                rblv_d = mem_v_q[rv_row];
            end
        end
    end

    always_comb begin
        fcnt_d = fcnt_q;
        freq_d = freq_q;
        if (!ROSC_GLOBAL_EN) begin
            fcnt_d = '0;
            freq_d = 1'b0;
        end else if (fcnt_q == FW'(FREQ_DIV - 1)) begin
            fcnt_d = '0;
            freq_d = ~freq_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
    assign samp_d = SAMPLE;

    always_comb begin
        state_d  = state_q;
        acnt_d   = acnt_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        spin_d   = spin_q;
        shadow_d = shadow_q;
        scnt_d   = scnt_q;
        first_d  = first_q;
        case (state_q)
            S_IDLE: begin
                if (sample_rise && ROSC_GLOBAL_EN) begin
                    state_d = S_ANNEAL;
                    acnt_d  = AW'(ANNEAL_CYC - 1);
                    busy_d  = 1'b1;
                end
            end
            S_ANNEAL: begin
                // Losing the oscillator abandons the sample without touching SPIN_OUT.
                if (!ROSC_GLOBAL_EN) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    shadow_d = {shadow_q[ST-2:0], lfsr_q[0]};
                    if (acnt_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        acnt_d = acnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                spin_d  = first_q ? SEED_PATTERN : shadow_q;
                first_d = 1'b0;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (scnt_q != 16'hFFFF) begin
                    scnt_d = scnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                mem_h_q[i] <= '0;
                mem_v_q[i] <= '0;
            end
            rblh_q   <= '0;
            rblv_q   <= '0;
            fcnt_q   <= '0;
            freq_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            state_q  <= S_IDLE;
            acnt_q   <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            spin_q   <= '0;
            shadow_q <= '0;
            scnt_q   <= '0;
            first_q  <= 1'b1;
            samp_q   <= 1'b0;
        end else begin
            mem_h_q  <= mem_h_d;
            mem_v_q  <= mem_v_d;
            rblh_q   <= rblh_d;
            rblv_q   <= rblv_d;
            fcnt_q   <= fcnt_d;
            freq_q   <= freq_d;
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            acnt_q   <= acnt_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            spin_q   <= spin_d;
            shadow_q <= shadow_d;
            scnt_q   <= scnt_d;
            first_q  <= first_d;
            samp_q   <= samp_d;
        end
    end

    assign RBLH        = rblh_q;
    assign RBLV        = rblv_q;
    assign FREQ_OUT    = freq_q;
    assign SPIN_OUT    = spin_q;
    assign SPIN_VALID  = valid_q;
    assign SAMPLE_BUSY = busy_q;
    assign SAMPLE_CNT  = scnt_q;

endmodule

// File: tb/tb_ising_array_model_param.sv
// Bench for ising_array_model_param: weight matrix / spin-history model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_ising_array_model_param;

    localparam int N  = 50;
    localparam int WW = 4;
    localparam int SW = 7;
    localparam int AC = 16;
    localparam int FD = 4;
    localparam int RW = N * WW;
    localparam int ST = N * SW;
    localparam logic [ST-1:0] SEED = '0;
    localparam logic [31:0]   LSEED = 32'h1;

    logic          clk;
    logic          rst, pre_n, rosc, sample, wenb, shil;
    logic [N-1:0]  wwl, rwlh, rwlv;
    logic [RW-1:0] wbl;
    logic [RW-1:0] rblh, rblv;
    logic          freq_out, spin_valid, sample_busy;
    logic [ST-1:0] spin_out;
    logic [15:0]   sample_cnt;

    int n_chk = 0;
    int n_fail = 0;

    ising_array_model_param #(
        .N(N), .WEIGHT_W(WW), .SPIN_W(SW), .ANNEAL_CYC(AC), .FREQ_DIV(FD),
        .SEED_PATTERN(SEED), .LFSR_SEED(LSEED)
    ) dut (
        .CLK(clk), .RST(rst), .PRE_CHARGE_ENB(pre_n), .ROSC_GLOBAL_EN(rosc),
        .SAMPLE(sample), .WEIGHT_ENB(wenb), .SHIL_WEIGHT_ENB(shil),
        .WWL(wwl), .WBL(wbl), .RWLH(rwlh), .RWLV(rwlv),
        .RBLH(rblh), .RBLV(rblv), .FREQ_OUT(freq_out), .SPIN_OUT(spin_out),
        .SPIN_VALID(spin_valid), .SAMPLE_BUSY(sample_busy), .SAMPLE_CNT(sample_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [ST-1:0] act, input logic [ST-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic int wl_dec(input logic [N-1:0] wl);
        for (int i = N - 1; i >= 0; i--) begin
            if (wl[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [RW-1:0] fill(input logic [3:0] v);
        logic [RW-1:0] x;
        for (int c = 0; c < N; c++) x[c*WW +: WW] = v;
        return x;
    endfunction

    // Model: weight matrix w[row][col]; V readback is just its transpose.
    logic [3:0]    w [N][N];
    logic [31:0]   m_lfsr;
    logic [ST-1:0] m_shadow, exp_spin;
    logic [RW-1:0] exp_rblh, exp_rblv;
    logic          exp_valid, exp_busy, exp_freq;
    logic [15:0]   exp_cnt;
    int            remaining, en_run, m_rh, m_rv, m_wr;
    bit            pending, first, prev_s, model_live;

    initial begin
        model_live = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) w[r][c] = 4'h0;
                m_lfsr = LSEED; m_shadow = '0; exp_spin = '0;
                exp_rblh = '0; exp_rblv = '0;
                exp_valid = 0; exp_busy = 0; exp_freq = 0; exp_cnt = '0;
                remaining = 0; en_run = 0; pending = 0; first = 1; prev_s = 0;
                model_live = 1;
            end else begin
                m_rh = wl_dec(rwlh);
                m_rv = wl_dec(rwlv);
                if (!pre_n) begin
                    exp_rblh = '1;
                    exp_rblv = '1;
                end else begin
                    if (m_rh >= 0) for (int c = 0; c < N; c++) exp_rblh[c*WW +: WW] = w[m_rh][c];
                    if (m_rv >= 0) for (int c = 0; c < N; c++) exp_rblv[c*WW +: WW] = w[c][m_rv];
                end
                m_wr = wl_dec(wwl);
                if (m_wr >= 0) begin
                    if (!wenb) begin
                        for (int c = 0; c < N; c++) w[m_wr][c] = wbl[c*WW +: WW];
                    end else if (!shil) begin
                        w[m_wr][m_wr] = wbl[m_wr*WW +: WW];
                    end
                end
                en_run   = rosc ? en_run + 1 : 0;
                exp_freq = ((en_run / FD) % 2) == 1;
                exp_valid = 0;
                if (pending) begin
                    exp_spin  = first ? SEED : m_shadow;
                    first     = 0;
                    exp_valid = 1;
                    exp_busy  = 0;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    pending   = 0;
                end else if (remaining > 0) begin
                    if (!rosc) begin
                        remaining = 0;
                        exp_busy  = 0;
                    end else begin
                        m_shadow  = {m_shadow[ST-2:0], m_lfsr[0]};
                        remaining = remaining - 1;
                        if (remaining == 0) pending = 1;
                    end
                end else if (sample && !prev_s && rosc) begin
                    remaining = AC;
                    exp_busy  = 1;
                end
                prev_s = sample;
                m_lfsr = lfsr_step(m_lfsr);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (model_live) begin
                chk("cyc_rblh", rblh, exp_rblh);
                chk("cyc_rblv", rblv, exp_rblv);
                chk("cyc_freq", freq_out, exp_freq);
                chk("cyc_spin", spin_out, exp_spin);
                chk("cyc_valid", spin_valid, exp_valid);
                chk("cyc_busy", sample_busy, exp_busy);
                chk("cyc_cnt", sample_cnt, exp_cnt);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_row(input int r, input logic [3:0] v, input logic wenb_v, input logic shil_v);
        @(negedge clk);
        wwl = '0;
        wwl[r] = 1'b1;
        wbl = fill(v);
        wenb = wenb_v;
        shil = shil_v;
        @(negedge clk);
        wwl = '0;
        wenb = 1'b1;
        shil = 1'b1;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (spin_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [RW-1:0] ramp;
    int lat, nv, k, per;

    initial begin
        rst = 1; pre_n = 1; rosc = 0; sample = 0; wenb = 1; shil = 1;
        wwl = '0; wbl = '0; rwlh = '0; rwlv = '0;
        repeat (3) @(negedge clk);
        chk("rst_cnt", sample_cnt, 16'd0);
        chk("rst_spin", spin_out, '0);
        chk("rst_rblh", rblh, '0);
        chk("rst_busy", sample_busy, 1'b0);
        chk("model_lfsr1", lfsr_step(32'h1), 32'h8020_0003);
        chk("model_lfsr2", lfsr_step(32'h8020_0003), 32'hC030_0002);
        rst = 0;

        write_row(2, 4'h2, 1'b0, 1'b1);
        write_row(9, 4'h9, 1'b0, 1'b1);
        write_row(7, 4'h3, 1'b0, 1'b1);

        // Row 3 ramp write with a same-cycle read of the old contents.
        for (int c = 0; c < N; c++) ramp[c*WW +: WW] = 4'(c);
        wwl = '0; wwl[3] = 1'b1; wbl = ramp; wenb = 1'b0;
        rwlh = '0; rwlh[3] = 1'b1;
        @(negedge clk);
        chk("rd_old_data", rblh, '0);
        wwl = '0; wenb = 1'b1;
        rwlv = '0; rwlv[5] = 1'b1;
        @(negedge clk);
        chk("row3_ramp", rblh, ramp);
        chk("col5_field3", rblv[3*WW +: WW], 4'h5);

        write_row(7, 4'hA, 1'b1, 1'b0);
        rwlh = '0; rwlh[7] = 1'b1;
        rwlv = '0; rwlv[7] = 1'b1;
        @(negedge clk);
        chk("shil_h77", rblh[7*WW +: WW], 4'hA);
        chk("shil_h76", rblh[6*WW +: WW], 4'h3);
        chk("shil_v77", rblv[7*WW +: WW], 4'hA);
        chk("shil_v37", rblv[3*WW +: WW], 4'h7);

        write_row(10, 4'h5, 1'b0, 1'b0);
        rwlh = '0; rwlh[10] = 1'b1;
        @(negedge clk);
        chk("both_low_full", rblh, fill(4'h5));

        rwlh = '0; rwlh[3] = 1'b1; pre_n = 1'b0;
        @(negedge clk);
        chk("precharge_h", rblh, {RW{1'b1}});
        chk("precharge_v", rblv, {RW{1'b1}});
        pre_n = 1'b1;
        rwlh = '0; rwlh[2] = 1'b1; rwlh[9] = 1'b1;
        @(negedge clk);
        chk("multi_wl_hi", rblh, fill(4'h9));
        rwlh = '0;
        @(negedge clk);
        chk("rwl_zero_hold", rblh, fill(4'h9));

        sample = 1;
        repeat (2) @(negedge clk);
        chk("ign_rosc_low", sample_busy, 1'b0);
        sample = 0;

        rosc = 1;
        repeat (3) @(negedge clk);
        sample = 1;
        wait_valid(lat);
        chk("lat_first", lat - 1, 17);
        chk("spin_seed", spin_out, '0);
        chk("cnt_one", sample_cnt, 16'd1);
        sample = 0;

        repeat (3) @(negedge clk);
        sample = 1;
        @(negedge clk);
        sample = 0;
        repeat (4) @(negedge clk);
        sample = 1;
        @(negedge clk);
        sample = 0;
        wait_valid(lat);
        chk("cnt_two", sample_cnt, 16'd2);

        repeat (3) @(negedge clk);
        sample = 1;
        repeat (5) @(negedge clk);
        rosc = 0;
        sample = 0;
        @(negedge clk);
        chk("abort_freq", freq_out, 1'b0);
        chk("abort_busy", sample_busy, 1'b0);
        nv = 0;
        repeat (30) begin
            @(negedge clk);
            if (spin_valid) nv++;
        end
        chk("abort_no_valid", nv, 0);
        chk("abort_cnt", sample_cnt, 16'd2);

        rosc = 1;
        k = 0;
        while (!freq_out && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("freq_first", k, 4);
        per = 0;
        do begin
            @(negedge clk);
            per++;
        end while (freq_out && per < 50);
        while (!freq_out && per < 50) begin
            @(negedge clk);
            per++;
        end
        chk("freq_period", per, 8);

        sample = 0;
        @(negedge clk);
        sample = 1;
        repeat (5) @(negedge clk);
        rst = 1;
        sample = 0;
        @(negedge clk);
        chk("midrst_spin", spin_out, '0);
        chk("midrst_cnt", sample_cnt, 16'd0);
        chk("midrst_busy", sample_busy, 1'b0);
        chk("midrst_valid", spin_valid, 1'b0);
        chk("midrst_freq", freq_out, 1'b0);
        chk("midrst_rblh", rblh, '0);
        rst = 0;
        repeat (3) @(negedge clk);
        sample = 1;
        wait_valid(lat);
        chk("lat_after_rst", lat - 1, 17);
        chk("seed_after_rst", spin_out, '0);
        chk("cnt_after_rst", sample_cnt, 16'd1);
        sample = 0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
